// File: rtl/puf_challenge_sequencer.sv
// Purpose: initiator-side sequencer for the multi-bit PUF. It sweeps a challenge range,
//   evaluates each challenge N_EVAL times, majority-votes every response bit and streams
//   {resp_addr, resp_data, resp_unstable} out on a valid/ready port.
// Latency: N_EVAL*(SETTLE_CYCLES+3) cycles from PRST entry to resp_valid for each challenge.
// Backpressure: EMIT holds all resp_* outputs stable until resp_ready; the PUF is held in reset meanwhile.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   go, addr_first, addr_last  - sweep request and inclusive range (range may wrap)
//   puf_start/addr/reset       - drive the PUF; puf_out is its DATA_W-bit response
//   resp_valid/ready/data/addr - voted response stream; resp_unstable flags non-unanimous bits
//   busy, done                 - busy while not IDLE; done pulses once after the final handshake
module puf_challenge_sequencer #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int N_EVAL        = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr_first,
  input  logic [ADDR_W-1:0] addr_last,
  output logic              puf_start,
  output logic [ADDR_W-1:0] puf_addr,
  output logic              puf_reset,
  input  logic [DATA_W-1:0] puf_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_unstable,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(N_EVAL + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0]     N_FULL      = CW'(N_EVAL);
  localparam logic [CW-1:0]     N_LAST      = CW'(N_EVAL - 1);
  localparam logic [CW-1:0]     N_HALF      = CW'(N_EVAL / 2);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]     SETTLE_ONE  = SW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRST, S_ARM, S_SETTLE, S_SAMPLE, S_EMIT
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        cur_q, cur_d;
  logic [ADDR_W-1:0]        last_q, last_d;
  logic [DATA_W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]            eval_q, eval_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic                     done_q, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_PRST;
      S_PRST:   state_d = S_ARM;
      S_ARM:    state_d = S_SETTLE;
      S_SETTLE: if (settle_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (eval_q == N_LAST) ? S_EMIT : S_PRST;
      S_EMIT:   if (resp_ready) state_d = (cur_q == last_q) ? S_IDLE : S_PRST;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    puf_reset  = 1'b1;
    puf_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      S_IDLE:                      busy = 1'b0;
      S_PRST:                      ;
      S_ARM, S_SETTLE, S_SAMPLE: begin
        puf_reset = 1'b0;
        puf_start = 1'b1;
      end
      S_EMIT:                      resp_valid = 1'b1;
      default:                     busy = 1'b0;
    endcase
  end

  // Datapath next-state: range latch, vote counters, eval and settle counters
  always_comb begin
    cur_d    = cur_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    eval_d   = eval_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_d  = addr_first;
          last_d = addr_last;
          cnt_d  = '0;
          eval_d = '0;
        end
      end
      S_ARM:    settle_d = SETTLE_LOAD;
      S_SETTLE: if (settle_q != '0) settle_d = settle_q - SETTLE_ONE;
      S_SAMPLE: begin
        for (int i = 0; i < DATA_W; i++) begin
          if (puf_out[i]) cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
        eval_d = eval_q + CNT_ONE;
      end
      S_EMIT: begin
        if (resp_ready) begin
          cnt_d  = '0;
          eval_d = '0;
          // Range end compares against the latched last address, so a wrapped
          // range naturally rolls through 2^ADDR_W-1 to 0.
          if (cur_q == last_q) done_d = 1'b1;
          else                 cur_d  = cur_q + ADDR_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      eval_q   <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      eval_q   <= eval_d;
      settle_q <= settle_d;
      done_q   <= done_d;
    end
  end

  // Vote decode works purely from registered counts, so no input reaches an output.
  always_comb begin
    resp_data     = '0;
    resp_unstable = '0;
    for (int i = 0; i < DATA_W; i++) begin
      resp_data[i]     = (cnt_q[i] > N_HALF);
      resp_unstable[i] = (cnt_q[i] != '0) && (cnt_q[i] != N_FULL);
    end
  end

  assign puf_addr  = cur_q;
  assign resp_addr = cur_q;
  assign done      = done_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NE = 5;
  localparam int SC = 16;
  localparam int LAT = NE * (SC + 3);

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [AW-1:0] addr_first, addr_last;
  logic          puf_start, puf_reset;
  logic [AW-1:0] puf_addr;
  logic [DW-1:0] puf_out;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data, resp_unstable;
  logic [AW-1:0] resp_addr;
  logic          busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  puf_challenge_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .N_EVAL(NE), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .addr_first(addr_first), .addr_last(addr_last),
    .puf_start(puf_start), .puf_addr(puf_addr), .puf_reset(puf_reset),
    .puf_out(puf_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_addr(resp_addr), .resp_unstable(resp_unstable),
    .busy(busy), .done(done)
  );

  // PUF model: response per (address, evaluation index). The evaluation index
  // advances on each rising edge of puf_start; garbage is driven while in reset.
  logic [DW-1:0] pat [16][NE];
  int   ev_next = 0;
  int   ev_cur  = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (reset || resp_valid) ev_next = 0;
    else if (puf_start && !prev_start) begin
      ev_cur = (ev_next < NE) ? ev_next : NE - 1;
      ev_next++;
    end
    prev_start = puf_start;
    if (puf_reset) puf_out = DW'($urandom);
    else           puf_out = pat[puf_addr][ev_cur];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference vote: count ones per bit across all evaluations.
  function automatic void ref_vote(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                   output logic [DW-1:0] u);
    d = '0;
    u = '0;
    for (int b = 0; b < DW; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < NE; k++) ones += int'(pat[a][k][b]);
      d[b] = (2 * ones > NE);
      u[b] = (ones != 0) && (ones != NE);
    end
  endfunction

  task automatic start_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l);
    addr_first = f;
    addr_last  = l;
    go = 1'b1;
    cycle();
    go = 1'b0;
  endtask

  // Single-challenge sweep with hand-computed expectations; checks latency and done pulse.
  task automatic run_single(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [DW-1:0] eu);
    int   lat;
    logic addr_ok;
    start_sweep(a, a);
    lat = 0;
    addr_ok = 1'b1;
    while (!resp_valid && lat < 4 * LAT) begin
      addr_ok &= (puf_addr == a);
      cycle();
      lat++;
    end
    chk("latency", lat, LAT);
    chk("puf_addr_stable", addr_ok, 1);
    chk("single_resp_addr", resp_addr, a);
    chk("single_resp_data", resp_data, ed);
    chk("single_resp_unstable", resp_unstable, eu);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("done_after_handshake", done, 1);
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", resp_valid, 0);
    cycle();
    chk("done_one_cycle", done, 0);
  endtask

  // Consume a running sweep with random backpressure, checking order and votes.
  task automatic collect(input logic [AW-1:0] f, input logic [AW-1:0] l, input int pct);
    logic [AW-1:0] q[$];
    logic [AW-1:0] a;
    logic [DW-1:0] ed, eu;
    int idx, guard, budget;
    a = f;
    q.push_back(a);
    while (a != l) begin
      a++;
      q.push_back(a);
    end
    budget = q.size() * (LAT + 60) + 100;
    idx = 0;
    guard = 0;
    while (idx < q.size() && guard < budget) begin
      resp_ready = ($urandom_range(0, 99) < pct);
      if (resp_valid && resp_ready) begin
        ref_vote(q[idx], ed, eu);
        chk("sweep_resp_addr", resp_addr, q[idx]);
        chk("sweep_resp_data", resp_data, ed);
        chk("sweep_resp_unstable", resp_unstable, eu);
        idx++;
      end
      cycle();
      guard++;
    end
    resp_ready = 1'b0;
    if (idx < q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_timeout: got %0d responses expected %0d", idx, q.size());
    end else begin
      chk("sweep_done", done, 1);
      chk("sweep_busy_low", busy, 0);
    end
  endtask

  typedef struct {
    logic [AW-1:0]   addr;
    logic [NE*8-1:0] pv;   // eval k in byte k
    logic [DW-1:0]   ed;
    logic [DW-1:0]   eu;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    logic [AW-1:0] f, l;

    vecs[0] = '{addr: 4'd3,  pv: {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5}, ed: 8'hA5, eu: 8'h00};
    vecs[1] = '{addr: 4'd7,  pv: {8'h00, 8'h01, 8'h00, 8'h01, 8'h01}, ed: 8'h01, eu: 8'h01};
    vecs[2] = '{addr: 4'd7,  pv: {8'h01, 8'h00, 8'h00, 8'h00, 8'h01}, ed: 8'h00, eu: 8'h01};
    vecs[3] = '{addr: 4'd0,  pv: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF}, ed: 8'hFF, eu: 8'hFF};
    vecs[4] = '{addr: 4'd15, pv: {8'hFF, 8'h00, 8'h3C, 8'hF0, 8'h0F}, ed: 8'h3C, eu: 8'hFF};
    vecs[5] = '{addr: 4'd9,  pv: {8'h81, 8'h80, 8'h80, 8'h80, 8'h80}, ed: 8'h80, eu: 8'h01};

    for (int a = 0; a < 16; a++)
      for (int k = 0; k < NE; k++) pat[a][k] = '0;

    reset = 1'b1;
    go = 1'b0;
    addr_first = '0;
    addr_last = '0;
    resp_ready = 1'b0;
    repeat (3) cycle();

    // Reset state
    chk("rst_puf_reset", puf_reset, 1);
    chk("rst_puf_start", puf_start, 0);
    chk("rst_puf_addr", puf_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_unstable", resp_unstable, 0);
    chk("rst_resp_addr", resp_addr, 0);
    reset = 1'b0;
    cycle();
    chk("idle_busy", busy, 0);

    // Table-driven single-challenge votes
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < NE; k++) pat[vecs[v].addr][k] = vecs[v].pv[k*8 +: 8];
      run_single(vecs[v].addr, vecs[v].ed, vecs[v].eu);
    end

    // Backpressure: EMIT held for 20 cycles
    for (int k = 0; k < NE; k++) pat[3][k] = 8'hA5;
    start_sweep(4'd3, 4'd3);
    for (int i = 0; i < 4 * LAT && !resp_valid; i++) cycle();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stable &= resp_valid && (resp_data == 8'hA5) && (resp_addr == 4'd3) &&
                (resp_unstable == 8'h00) && !puf_start && puf_reset && (puf_addr == 4'd3);
      cycle();
    end
    chk("bp_hold_stable", stable, 1);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("bp_done", done, 1);

    // Wrapping sweep 14 -> 1
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < NE; k++) pat[a][k] = DW'($urandom) ^ DW'($urandom & $urandom & $urandom);
    start_sweep(4'd14, 4'd1);
    collect(4'd14, 4'd1, 60);
    stable = 1'b1;
    repeat (5) begin
      cycle();
      stable &= !resp_valid && !busy;
    end
    chk("wrap_no_extra_response", stable, 1);

    // Reset in the third SETTLE phase: no stale counts afterwards
    for (int k = 0; k < NE; k++) pat[5][k] = 8'hFF;
    start_sweep(4'd5, 4'd5);
    repeat (2 * (SC + 3) + 8) cycle();
    chk("mid_settle_start", puf_start, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_puf_reset", puf_reset, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_puf_start", puf_start, 0);
    chk("midrst_no_done", done, 0);
    pat[5][0] = 8'h00; pat[5][1] = 8'h00; pat[5][2] = 8'h00;
    pat[5][3] = 8'hFF; pat[5][4] = 8'hFF;
    run_single(4'd5, 8'h00, 8'hFF);

    // go pulsed while busy is ignored
    start_sweep(4'd2, 4'd3);
    repeat (10) cycle();
    addr_first = 4'd9;
    addr_last  = 4'd9;
    go = 1'b1;
    cycle();
    go = 1'b0;
    collect(4'd2, 4'd3, 70);
    repeat (5) cycle();
    chk("go_busy_ignored", busy, 0);

    // go held through sweep end restarts the cycle after done
    addr_first = 4'd4;
    addr_last  = 4'd4;
    go = 1'b1;
    cycle();
    collect(4'd4, 4'd4, 100);
    cycle();
    go = 1'b0;
    chk("go_held_restart_busy", busy, 1);
    chk("go_held_restart_addr", puf_addr, 4);
    chk("go_held_restart_prst", puf_reset, 1);
    collect(4'd4, 4'd4, 100);

    // Randomized sweeps against the reference vote
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 16; a++)
        for (int k = 0; k < NE; k++) pat[a][k] = DW'($urandom) ^ DW'($urandom & $urandom);
      f = AW'($urandom);
      l = AW'($urandom);
      start_sweep(f, l);
      collect(f, l, $urandom_range(40, 100));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Initiator-side controller for the on-chip multi-bit PUF; it is the reader that drives the PUF's START/addr/reset inputs and consumes its 8-bit OUT.
For each challenge address in a programmed range it evaluates the PUF N_EVAL times and majority-votes every response bit.
It then presents the voted response, its address and an instability mask on a valid/ready stream to the downstream readout logic.

Parameters:
ADDR_W, 4, challenge address width (matches PUF addr)
DATA_W, 8, response width (matches PUF OUT)
N_EVAL, 5, evaluations per challenge; odd, 1..15
SETTLE_CYCLES, 16, cycles the PUF runs after START before sampling; >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
go  in  1  start a sweep; sampled only in IDLE
addr_first  in  ADDR_W  first challenge of sweep, latched on go
addr_last  in  ADDR_W  last challenge of sweep, latched on go
puf_start  out  1  drives PUF START
puf_addr  out  ADDR_W  drives PUF addr
puf_reset  out  1  drives PUF reset (active-high)
puf_out  in  DATA_W  PUF response
resp_valid  out  1  voted response available
resp_ready  in  1  downstream accepts response
resp_data  out  DATA_W  majority-voted response
resp_addr  out  ADDR_W  challenge for resp_data
resp_unstable  out  DATA_W  bit set = votes for that bit not unanimous
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Reset (synchronous, priority over everything):
  - State goes to IDLE.
  - All outputs are 0 except puf_reset=1.
  - Vote counters and eval counter are cleared.
  - Reset mid-sweep abandons the sweep with no done pulse and drops resp_valid in the next cycle.
- States:
  - IDLE: puf_reset=1, puf_start=0.
    - go=1 latches addr_first/addr_last, sets cur=addr_first, clears counters, goes to PRST.
  - PRST (1 cycle): puf_reset=1, puf_start=0, puf_addr=cur. Goes to ARM.
  - ARM (1 cycle): puf_reset=0, puf_start=1. Loads settle counter with SETTLE_CYCLES-1. Goes to SETTLE.
  - SETTLE: puf_start=1; counter decrements each cycle; at 0 goes to SAMPLE.
  - SAMPLE (1 cycle): puf_start=1; registers puf_out.
    - For every bit i with puf_out[i]=1, cnt[i] is incremented; cnt width is clog2(N_EVAL+1).
    - Eval counter increments.
    - If eval count reaches N_EVAL, go to EMIT; else go to PRST for the next evaluation.
  - EMIT: puf_reset=1, puf_start=0.
    - resp_data[i] = (cnt[i] > N_EVAL/2).
    - resp_unstable[i] = (cnt[i] != 0 && cnt[i] != N_EVAL).
    - resp_addr = cur; resp_valid=1.
    - resp_valid, resp_data, resp_addr and resp_unstable are held stable until resp_valid && resp_ready.
    - On handshake: counters clear.
      - If cur==addr_last: go to IDLE with done=1 for that transition cycle.
      - Else: cur = cur+1 (wraps modulo 2^ADDR_W), go to PRST.
- Timing: latency per challenge from PRST entry to resp_valid = N_EVAL*(SETTLE_CYCLES+3) cycles.
- Range: addr_last < addr_first is legal.
  - The sweep wraps through 2^ADDR_W-1 to 0 and ends at addr_last.
  - addr_first==addr_last gives exactly one response.
- Handshake: resp_ready is ignored outside EMIT. resp_valid never drops without a handshake except on reset.
- go is ignored while busy=1. go asserted in the same cycle as reset is ignored.
- puf_addr is stable for the entire PRST..SAMPLE window of a challenge. It changes only on EMIT exit.
- All outputs are registered; no combinational path from puf_out or resp_ready to any output.

Test Plan:
1. PUF model returns constant 8'hA5 for addr 3; go with first=last=3 -> one response: resp_data=A5, resp_unstable=00, resp_addr=3, resp_valid first high exactly 5*19=95 cycles after PRST entry, done pulse one cycle after handshake.
2. Noisy model, addr 7, bit0 returns 1,1,0,1,0 over the five evals, other bits constant 0 -> resp_data=01, resp_unstable=01; with bit0 pattern 1,0,0,0,1 -> resp_data=00, resp_unstable=01.
3. Backpressure: resp_ready low for 20 cycles during EMIT -> resp_valid/resp_data/resp_addr stay constant, puf_start=0, puf_addr unchanged, no new PRST until handshake.
4. Wrap sweep first=14, last=1 -> responses in order addr 14,15,0,1, exactly four handshakes, then done and busy=0.
5. Reset asserted in the third SETTLE phase of addr 5 -> next cycle busy=0, puf_reset=1, resp_valid=0; a new go for addr 5 yields a clean vote with no stale counts.
6. go pulsed while busy -> ignored, range unchanged; go held high through sweep end -> new sweep starts the cycle after done.
